// File: rtl/dds_pkg.sv
// dds_pkg: register map, opcodes, wave/FSM encodings and LFSR constants shared by
// the dds_voice_engine slice.
package dds_pkg;

    localparam logic [3:0] REG_TUNE  = 4'd0;
    localparam logic [3:0] REG_CTRL  = 4'd1;
    localparam logic [3:0] REG_PW    = 4'd2;
    localparam logic [3:0] REG_ATTEN = 4'd3;
    localparam logic [3:0] REG_PHASE = 4'd4;

    localparam logic [7:0] CMD_CLR_OVERRUN = 8'hFF;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        WAVE_SAW    = 3'd0,
        WAVE_SQUARE = 3'd1,
        WAVE_TRI    = 3'd2,
        WAVE_NOISE  = 3'd3
    } wave_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/dds_voice_engine_if.sv
// dds_voice_engine_if: register-write, sample-request and mixed-sample signals of
// dds_voice_engine; master = controller side, slave = engine side.
interface dds_voice_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 16
);
    logic              cmd_valid;
    logic [7:0]        cmd_word;
    logic [DATA_W-1:0] data_word;
    logic              sample_tick;
    logic [OUT_W-1:0]  sample_out;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output cmd_valid, cmd_word, data_word, sample_tick,
        input  sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  cmd_valid, cmd_word, data_word, sample_tick,
        output sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/dds_wavegen.sv
// dds_wavegen: combinational waveform shaper for one voice slot; noise is muxed in
// by the parent, so select 3 and 4..7 yield mid-scale here.
module dds_wavegen #(
    parameter int unsigned WAVE_W = 12
) (
    input  logic [WAVE_W-1:0] i_phase_top,
    input  logic [WAVE_W-1:0] i_pw,
    input  logic [2:0]        i_sel,
    output logic [WAVE_W-1:0] o_wave
);
    import dds_pkg::*;

    localparam logic [WAVE_W-1:0] MID = {1'b1, {(WAVE_W-1){1'b0}}};

    logic [WAVE_W-1:0] w_dbl;
    assign w_dbl = {i_phase_top[WAVE_W-2:0], 1'b0};

    always_comb begin
        o_wave = MID;
        case (i_sel)
            WAVE_SAW:    o_wave = i_phase_top;
            WAVE_SQUARE: o_wave = (i_phase_top < i_pw) ? '1 : '0;
            WAVE_TRI:    o_wave = i_phase_top[WAVE_W-1] ? ~w_dbl : w_dbl;
            default:     o_wave = MID;
        endcase
    end
endmodule

// File: rtl/dds_voice_engine.sv
// dds_voice_engine: time-multiplexed N-voice DDS, one voice per cycle, mixed into an
// offset-binary sample. Define DDS_NOISE_EN to build the shared LFSR noise source.
module dds_voice_engine #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned TUNE_W     = 16,
    parameter int unsigned WAVE_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_W      = 16
) (
    input logic                sys_clk,
    input logic                rst,
    dds_voice_engine_if.slave  bus
);
    import dds_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W = WAVE_W + $clog2(NUM_VOICES);
    localparam int unsigned SH    = OUT_W - ACC_W;
    localparam logic [OUT_W-1:0] MID_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    logic [TUNE_W-1:0] r_tune  [NUM_VOICES];
    logic [TUNE_W-1:0] r_phase [NUM_VOICES];
    logic [WAVE_W-1:0] r_pw    [NUM_VOICES];
    logic [2:0]        r_sel   [NUM_VOICES];
    logic [2:0]        r_atten [NUM_VOICES];
    logic              r_en    [NUM_VOICES];

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_flush_last;
    logic               r_s0_vld;
    logic               r_s0_en;
    logic [WAVE_W-1:0]  r_s0_wave;
    logic [2:0]         r_s0_atten;
    logic signed [ACC_W-1:0] r_acc;

    logic [DATA_W-1:0]  w_data;
    logic [3:0]         w_wr_voice;
    logic [3:0]         w_wr_reg;
    logic               w_start;
    logic               w_tick_set;
    logic               w_clr;
    logic               w_last;
    logic [2:0]         w_sel;
    logic [WAVE_W-1:0]  w_gen_wave;
    logic [WAVE_W-1:0]  w_wave;
    logic signed [WAVE_W-1:0] w_v;
    logic signed [WAVE_W-1:0] w_v_att;
    logic signed [OUT_W-1:0]  w_ext;
    logic [OUT_W-1:0]   w_out;

    assign w_data     = bus.data_word;
    assign w_wr_voice = bus.cmd_word[7:4];
    assign w_wr_reg   = bus.cmd_word[3:0];
    assign w_clr      = bus.cmd_valid && (bus.cmd_word == CMD_CLR_OVERRUN);
    assign w_last     = (r_idx == IDX_W'(NUM_VOICES - 1));

    // The final flush edge both loads the output and may launch the next sweep.
    assign w_start    = bus.sample_tick &&
                        ((r_state == ST_IDLE) || ((r_state == ST_FLUSH) && r_flush_last));
    assign w_tick_set = bus.sample_tick && !w_start;
    assign bus.busy   = (r_state != ST_IDLE);

    assign w_sel = r_sel[r_idx];

    dds_wavegen #(.WAVE_W(WAVE_W)) u_wavegen (
        .i_phase_top (r_phase[r_idx][TUNE_W-1 -: WAVE_W]),
        .i_pw        (r_pw[r_idx]),
        .i_sel       (w_sel),
        .o_wave      (w_gen_wave)
    );

`ifdef DDS_NOISE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if ((r_state == ST_RUN) && (w_sel == WAVE_NOISE)) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_wave = (w_sel == WAVE_NOISE) ? r_lfsr[15 -: WAVE_W] : w_gen_wave;
`else
    assign w_wave = w_gen_wave;
`endif

    // Register file: sweep phase write-back first, so a phase-load command wins.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_tune[v]  <= '0;
                r_phase[v] <= '0;
                r_pw[v]    <= '0;
                r_sel[v]   <= '0;
                r_atten[v] <= '0;
                r_en[v]    <= 1'b0;
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if ((r_state == ST_RUN) && (r_idx == IDX_W'(v)) && r_en[v])
                    r_phase[v] <= r_phase[v] + r_tune[v];
                if (bus.cmd_valid && (w_wr_voice == 4'(v))) begin
                    case (w_wr_reg)
                        REG_TUNE:  r_tune[v]  <= w_data[TUNE_W-1:0];
                        REG_CTRL:  begin
                            r_en[v]  <= w_data[3];
                            r_sel[v] <= w_data[2:0];
                        end
                        REG_PW:    r_pw[v]    <= w_data[WAVE_W-1:0];
                        REG_ATTEN: r_atten[v] <= w_data[2:0];
                        REG_PHASE: r_phase[v] <= w_data[TUNE_W-1:0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign w_v     = $signed({~r_s0_wave[WAVE_W-1], r_s0_wave[WAVE_W-2:0]});
    assign w_v_att = w_v >>> r_s0_atten;
    assign w_ext   = OUT_W'(r_acc) <<< SH;
    assign w_out   = {~w_ext[OUT_W-1], w_ext[OUT_W-2:0]};

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_idx            <= '0;
            r_flush_last     <= 1'b0;
            r_s0_vld         <= 1'b0;
            r_s0_en          <= 1'b0;
            r_s0_wave        <= '0;
            r_s0_atten       <= '0;
            r_acc            <= '0;
            bus.sample_out   <= MID_OUT;
            bus.sample_valid <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;

            if (w_tick_set)
                bus.overrun <= 1'b1;
            else if (w_clr)
                bus.overrun <= 1'b0;

            r_s0_vld   <= (r_state == ST_RUN);
            r_s0_en    <= r_en[r_idx];
            r_s0_wave  <= w_wave;
            r_s0_atten <= r_atten[r_idx];

            if (w_start)
                r_acc <= '0;
            else if (r_s0_vld && r_s0_en)
                r_acc <= r_acc + ACC_W'(w_v_att);

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state      <= ST_FLUSH;
                        r_flush_last <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (!r_flush_last) begin
                        r_flush_last <= 1'b1;
                    end else begin
                        bus.sample_out   <= w_out;
                        bus.sample_valid <= 1'b1;
                        r_idx            <= '0;
                        r_state          <= w_start ? ST_RUN : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_voice_engine.sv
// tb_dds_voice_engine: drives register writes and sample ticks into dds_voice_engine
// and compares every mixed sample with an arithmetic model of the voice mix.
module tb_dds_voice_engine;
    localparam int NV = 4;

    logic sys_clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    int m_tune [NV];
    int m_en   [NV];
    int m_sel  [NV];
    int m_pw   [NV];
    int m_att  [NV];
    int m_phase[NV];
`ifdef DDS_NOISE_EN
    int m_lfsr;
`endif

    dds_voice_engine_if #(.DATA_W(16), .OUT_W(16)) bus ();

    dds_voice_engine #(
        .NUM_VOICES (4),
        .TUNE_W     (16),
        .WAVE_W     (12),
        .DATA_W     (16),
        .OUT_W      (16)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_tune[v] = 0; m_en[v] = 0; m_sel[v] = 0;
            m_pw[v] = 0; m_att[v] = 0; m_phase[v] = 0;
        end
`ifdef DDS_NOISE_EN
        m_lfsr = 'hACE1;
`endif
    endfunction

    function automatic void model_write(input int v, input int r, input int d);
        if (v >= NV) return;
        case (r)
            0: m_tune[v]  = d & 'hFFFF;
            1: begin m_en[v] = (d >> 3) & 1; m_sel[v] = d & 7; end
            2: m_pw[v]    = d & 'hFFF;
            3: m_att[v]   = d & 7;
            4: m_phase[v] = d & 'hFFFF;
            default: ;
        endcase
    endfunction

    // One full sweep: returns the expected sample and advances model state.
    function automatic logic [15:0] model_sweep();
        int s = 0;
        int p;
        int w;
        for (int v = 0; v < NV; v++) begin
            p = m_phase[v] / 16;
            case (m_sel[v])
                0: w = p;
                1: w = (p < m_pw[v]) ? 4095 : 0;
                2: w = (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
                3: begin
`ifdef DDS_NOISE_EN
                    w = m_lfsr / 16;
                    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
`else
                    w = 2048;
`endif
                end
                default: w = 2048;
            endcase
            if (m_en[v] != 0) begin
                s += (w - 2048) >>> m_att[v];
                m_phase[v] = (m_phase[v] + m_tune[v]) % 65536;
            end
        end
        return 16'(s * 4 + 32768);
    endfunction

    task automatic wr(input int v, input int r, input int d);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = 8'((v << 4) | r);
        bus.data_word = 16'(d);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        model_write(v, r, d);
    endtask

    // Tick at negedge 0; optional command at negedge wr_at and second tick at t2_at.
    task automatic run_sweep(input int wr_at, input logic [7:0] wc, input logic [15:0] wd,
                             input int t2_at, output int lat, output int lat2,
                             output int nvalid, output logic [15:0] smp,
                             output logic [15:0] smp2, output logic busy1,
                             output logic busyv);
        lat = -1; lat2 = -1; nvalid = 0; smp = '0; smp2 = '0; busy1 = 1'b0; busyv = 1'b1;
        @(negedge sys_clk);
        bus.sample_tick = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge sys_clk);
            if (k == 1) busy1 = bus.busy;
            if (bus.sample_valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    lat = k; smp = bus.sample_out; busyv = bus.busy;
                end else begin
                    lat2 = k; smp2 = bus.sample_out;
                end
            end
            bus.sample_tick = (k == t2_at);
            bus.cmd_valid   = (k == wr_at);
            bus.cmd_word    = wc;
            bus.data_word   = wd;
        end
        bus.sample_tick = 1'b0;
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (bus.sample_out !== 16'h8000) begin failures++; $display("FAIL reset_out got=%h exp=8000", bus.sample_out); end
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_silent();
        int lat, lat2, nv; logic [15:0] smp, smp2; logic b1, bv;
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== 16'h8000) begin failures++; $display("FAIL silent_out got=%h exp=8000", smp); end
        checks++; if (lat !== 7) begin failures++; $display("FAIL silent_latency got=%0d exp=7", lat); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL silent_valid_count got=%0d exp=1", nv); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL busy_after_tick got=%b exp=1", b1); end
        checks++; if (bv !== 1'b0) begin failures++; $display("FAIL busy_at_valid got=%b exp=0", bv); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL silent_overrun got=%b exp=0", bus.overrun); end
        void'(model_sweep());
    endtask

    task automatic test_saw();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        wr(0, 4, 0); wr(0, 0, 'h1000); wr(0, 3, 0); wr(0, 1, 8);
        for (int t = 0; t < 17; t++) begin
            exp = model_sweep();
            run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
            checks++; if (smp !== exp || lat !== 7) begin failures++; $display("FAIL saw_tick%0d got=%h lat=%0d exp=%h lat=7", t, smp, lat, exp); end
            if (t == 16) begin
                checks++; if (smp !== 16'h6000) begin failures++; $display("FAIL saw_wrap got=%h exp=6000", smp); end
            end
        end
    endtask

    task automatic test_square();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        for (int v = 0; v < NV; v++) begin
            wr(v, 4, 0); wr(v, 2, 'hFFF); wr(v, 3, 0); wr(v, 1, 9);
        end
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== 16'hFFF0) begin failures++; $display("FAIL square_full got=%h exp=fff0", smp); end
        checks++; if (smp !== exp) begin failures++; $display("FAIL square_model got=%h exp=%h", smp, exp); end
    endtask

    task automatic test_overrun();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, 2, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (nv !== 1) begin failures++; $display("FAIL overrun_single_valid got=%0d exp=1", nv); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
        checks++; if (smp !== exp) begin failures++; $display("FAIL overrun_sample got=%h exp=%h", smp, exp); end
        wr(15, 15, 0);
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", bus.overrun); end
        void'(model_sweep());
        run_sweep(3, 8'hFF, 16'h0, 3, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b exp=1", bus.overrun); end
        wr(15, 15, 0);
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear2 got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_write_during_sweep();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        for (int v = 0; v < NV; v++) wr(v, 1, 0);
        wr(2, 4, 0); wr(2, 0, 'h2000); wr(2, 3, 0); wr(2, 1, 8);
        exp = model_sweep();
        run_sweep(4, 8'h20, 16'h0100, -1, lat, lat2, nv, smp, smp2, b1, bv);
        model_write(2, 0, 'h0100);
        checks++; if (smp !== exp) begin failures++; $display("FAIL midsweep_s1 got=%h exp=%h", smp, exp); end
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== exp) begin failures++; $display("FAIL midsweep_s2 got=%h exp=%h", smp, exp); end
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== 16'h6840) begin failures++; $display("FAIL midsweep_newtune got=%h exp=6840", smp); end
        checks++; if (smp !== exp) begin failures++; $display("FAIL midsweep_s3 got=%h exp=%h", smp, exp); end
        wr(9, 0, 'hFFFF); wr(9, 1, 'hF); wr(9, 4, 'h1234);
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== exp) begin failures++; $display("FAIL bad_voice_ignored got=%h exp=%h", smp, exp); end
    endtask

    task automatic test_noise();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        for (int v = 0; v < NV; v++) wr(v, 1, 0);
        wr(0, 3, 0); wr(0, 1, 8 | 3);
        for (int t = 0; t < 3; t++) begin
            exp = model_sweep();
            run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
            checks++; if (smp !== exp) begin failures++; $display("FAIL noise_tick%0d got=%h exp=%h", t, smp, exp); end
            if (t == 0) begin
`ifdef DDS_NOISE_EN
                checks++; if (smp !== 16'h8B38) begin failures++; $display("FAIL noise_seed got=%h exp=8b38", smp); end
`else
                checks++; if (smp !== 16'h8000) begin failures++; $display("FAIL noise_disabled got=%h exp=8000", smp); end
`endif
            end
        end
        wr(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp, exp2; logic b1, bv;
        wr(1, 4, 'h3000); wr(1, 0, 'h0800); wr(1, 3, 1); wr(1, 1, 8 | 2);
        exp  = model_sweep();
        exp2 = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, 6, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (nv !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", nv); end
        checks++; if (lat2 !== 13) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=13", lat2); end
        checks++; if (smp !== exp || smp2 !== exp2) begin failures++; $display("FAIL b2b_samples got=%h,%h exp=%h,%h", smp, smp2, exp, exp2); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        int lat, lat2, nv, cnt; logic [15:0] smp, smp2, exp; logic b1, bv;
        wr(0, 4, 'h5000); wr(0, 0, 'h1000); wr(0, 1, 8);
        @(negedge sys_clk); bus.sample_tick = 1'b1;
        @(negedge sys_clk); bus.sample_tick = 1'b0;
        @(negedge sys_clk); rst = 1'b1;
        @(negedge sys_clk); rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (bus.sample_valid) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL reset_mid_valid got=%0d exp=0", cnt); end
        checks++; if (bus.busy !== 1'b0 || bus.sample_out !== 16'h8000) begin failures++; $display("FAIL reset_mid_state busy=%b out=%h exp busy=0 out=8000", bus.busy, bus.sample_out); end
        model_reset();
        wr(0, 0, 'h1000); wr(0, 1, 8);
        exp = model_sweep();
        run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
        checks++; if (smp !== exp) begin failures++; $display("FAIL reset_mid_phase got=%h exp=%h", smp, exp); end
    endtask

    task automatic test_random();
        int lat, lat2, nv; logic [15:0] smp, smp2, exp; logic b1, bv;
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NV; v++) begin
                wr(v, 0, int'($urandom_range(0, 'hFFFF)));
                wr(v, 1, int'($urandom_range(0, 15)));
                wr(v, 2, int'($urandom_range(0, 'hFFF)));
                wr(v, 3, int'($urandom_range(0, 7)));
                wr(v, 4, int'($urandom_range(0, 'hFFFF)));
            end
            wr(int'($urandom_range(0, 3)), int'($urandom_range(5, 14)), int'($urandom_range(0, 'hFFFF)));
            wr(int'($urandom_range(4, 15)), int'($urandom_range(0, 4)), int'($urandom_range(0, 'hFFFF)));
            for (int t = 0; t < 4; t++) begin
                exp = model_sweep();
                run_sweep(-1, 8'h00, 16'h0, -1, lat, lat2, nv, smp, smp2, b1, bv);
                checks++; if (smp !== exp || lat !== 7) begin failures++; $display("FAIL random_r%0d_t%0d got=%h lat=%0d exp=%h lat=7", r, t, smp, lat, exp); end
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_word    = 8'h00;
        bus.data_word   = 16'h0000;
        bus.sample_tick = 1'b0;
        model_reset();
        test_reset();
        test_silent();
        test_saw();
        test_square();
        test_overrun();
        test_write_during_sweep();
        test_noise();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dds_voice_engine.md
# dds_voice_engine

Time-multiplexed N-voice DDS core: one shared phase-accumulator and waveform datapath sweeps all voices once per sample request, applies per-voice attenuation, and sums the voices into one offset-binary sample for the DAC serialiser. It is the successor to the two fixed oscillators plus modulator: it sits between `cmd_decoder`-style register writes, driven by `spi_in` command/data words, and `spi_main_x2`.

## Interface
- `NUM_VOICES`, 4: voices swept per sample; 2..16.
- `TUNE_W`, 16: tuning word and phase-accumulator width.
- `WAVE_W`, 12: waveform sample width; must be ≤ `TUNE_W`.
- `DATA_W`, 16: command data width; must be ≥ `TUNE_W`.
- `OUT_W`, 16: output width; must be ≥ `WAVE_W + clog2(NUM_VOICES)`.

Ports:
- `sys_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: one-cycle write strobe.
- `cmd_word` in 8: `[7:4]` = voice index, `[3:0]` = register.
- `data_word` in `DATA_W`: write data.
- `sample_tick` in 1: one-cycle request for a new sample.
- `sample_out` out `OUT_W`: mixed sample, offset binary.
- `sample_valid` out 1: one-cycle strobe marking a new `sample_out`.
- `busy` out 1: high while a sweep is in progress.
- `overrun` out 1: sticky flag, set when `sample_tick` arrives while busy.

## Operation
- Per-voice registers. All reset to 0.
  - reg 0 `tune[TUNE_W-1:0]`.
  - reg 1 `{en, wave_sel[2:0]}` taken from `data_word[3:0]`.
  - reg 2 `pw[WAVE_W-1:0]`.
  - reg 3 `atten[2:0]`: arithmetic right shift of 0..7.
  - reg 4: phase load; sets `phase ← data_word[TUNE_W-1:0]`.
- Global commands:
  - `cmd_word` = 0xFF clears `overrun`.
  - A voice index ≥ `NUM_VOICES` or an unused register: write ignored.
- Writes take effect on the edge that samples `cmd_valid`.
- A sweep reads voice i's registers in the cycle it processes voice i. A write to a voice already processed applies from the next sweep.
- Waveform from `p = phase[TUNE_W-1 -: WAVE_W]`, unsigned:
  - 0 saw: `p`.
  - 1 square: all-ones if `p < pw`, else 0.
  - 2 triangle: `{p[WAVE_W-2:0],0}`, bitwise inverted when `p[WAVE_W-1]`.
  - 3 noise: see Configuration.
  - 4–7: mid-scale.
- Signed voice value: `v = wave ^ (1<<(WAVE_W-1))`, i.e. MSB inverted. It is then arithmetic-shifted right by `atten`.
- Disabled voice (`en`=0):
  - phase held;
  - contributes 0.
- Enabled voice: `phase ← phase + tune`, wrapping modulo 2^`TUNE_W`. This update is written back during its sweep slot.
- Accumulator:
  - signed, `WAVE_W + clog2(NUM_VOICES)` bits; cannot overflow.
  - Result is sign-extended, shifted left by `OUT_W − (WAVE_W + clog2(NUM_VOICES))`, then MSB inverted to give `sample_out`.
- FSM:
  - IDLE → RUN on `sample_tick`.
  - RUN: `idx` counts 0..`NUM_VOICES`−1, one voice per cycle.
  - RUN → FLUSH when the last voice is issued.
  - FLUSH: pipeline drains and the output register loads.
  - FLUSH → IDLE.
- `sample_tick` while not IDLE:
  - ignored;
  - `overrun` ← 1.
- Simultaneous `sample_tick` and 0xFF clear while busy: set wins.

## Timing
- Tick sampled at edge E0. Voice i is processed in the cycle after edge E0+i, i.e. in the stage-0 phase/wave registers.
- Stage 1 (attenuate and accumulate) follows one cycle later.
- `sample_out` and `sample_valid` update at edge E0+`NUM_VOICES`+2. `sample_valid` is high for exactly one cycle.
- `busy` is high from E0 until the edge that raises `sample_valid`. A tick in the same cycle that `sample_valid` is high is accepted.
- Minimum tick spacing: `NUM_VOICES`+2 cycles.
- Reset values:
  - `sample_out` = 1<<(`OUT_W`−1) (mid-scale);
  - `sample_valid`, `busy`, `overrun` = 0;
  - all phases and registers = 0;
  - FSM = IDLE.
- Reset mid-sweep: the sweep is aborted and no `sample_valid` is issued. Phases already written in that sweep are cleared by reset.

## Configuration
- `DDS_NOISE_EN` defined:
  - one shared 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset;
  - the LFSR advances once per voice processed with `wave_sel`=3;
  - the waveform is the LFSR's top `WAVE_W` bits.
- Undefined: `wave_sel`=3 outputs mid-scale and no LFSR is synthesised.

## Structure
- Package `dds_pkg`:
  - register-index constants;
  - wave-select enum;
  - FSM state enum;
  - global-clear opcode 0xFF;
  - LFSR seed and taps.
- One sub-module, `dds_wavegen`: combinational phase, `pw` and `sel` in, wave out, with the LFSR muxed in by the parent.
- The register file is flop arrays in the parent, indexed by `idx`.

## Test plan
- Reset, then one tick with all voices disabled → `sample_out` = 0x8000 at E0+6 (N=4); `sample_valid` high for one cycle.
- Voice 0:
  - setup: tune=0x1000, en, saw, atten 0, phase 0;
  - stimulus: 16 ticks;
  - expected: `sample_out` = `((phase>>4) ^ 0x800)` sign-extended, shifted left by 2, MSB inverted; the phase wraps to 0x0000 on the 16th tick.
- All 4 voices square, `pw`=0xFFF, phase 0, atten 0 → sum 4×2047 = 8188 → `sample_out` = 0x8000 + 8188×4 = 0xFFF0.
- Tick issued 2 cycles after a previous tick → `overrun`=1, a single `sample_valid`; then write 0xFF → `overrun`=0.
- Write voice 2's tune during voice-3 processing → takes effect next sweep. Write with voice index 9 → no register changes.
- `DDS_NOISE_EN` build, voice 0 noise, 3 ticks → wave values match the reference LFSR sequence from 0xACE1. Non-noise build → voice contributes 0.
